// File: rtl/muldiv_iter.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Retires one bit per cycle with the same latency for every operation.
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [2:0]       i_funct3,
    input  logic [WIDTH-1:0] i_rs1,
    input  logic [WIDTH-1:0] i_rs2,
    input  logic             i_kill,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0]   ONE_W  = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] ONE_2W = (2*WIDTH)'(1);
    localparam logic [CW-1:0]      CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [2:0]       f3_q, f3_d;
    logic             neg_a_q, neg_a_d;
    logic             neg_b_q, neg_b_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] a_raw_q, a_raw_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic accept, step, last;

    assign accept = ((state_q == S_IDLE) || (state_q == S_DONE)) && i_start && !i_kill;
    assign step   = (state_q == S_BUSY) && !i_kill;
    assign last   = (cnt_q == CNT_LAST);

    // Operand signedness is decided once, at accept, from funct3.
    logic             a_signed, b_signed, neg_a_in, neg_b_in;
    logic [WIDTH-1:0] mag_a_in, mag_b_in;

    assign a_signed = !((i_funct3 == 3'b011) || (i_funct3 == 3'b101) || (i_funct3 == 3'b111));
    assign b_signed = a_signed && (i_funct3 != 3'b010);
    assign neg_a_in = a_signed && i_rs1[WIDTH-1];
    assign neg_b_in = b_signed && i_rs2[WIDTH-1];
    assign mag_a_in = neg_a_in ? (~i_rs1 + ONE_W) : i_rs1;
    assign mag_b_in = neg_b_in ? (~i_rs2 + ONE_W) : i_rs2;

    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     shifted;
    logic               borrow;
    logic [WIDTH-1:0]   hi_step, lo_step;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix, result_fin;

    // One iteration: hi/lo hold the product (multiply) or remainder/quotient (divide).
    always_comb begin
        add_sum = {1'b0, hi_q} + {1'b0, (lo_q[0] ? b_q : {WIDTH{1'b0}})};
        shifted = {hi_q, lo_q[WIDTH-1]};
        borrow  = (shifted < {1'b0, b_q});
        if (f3_q[2]) begin
            hi_step = borrow ? shifted[WIDTH-1:0] : (shifted[WIDTH-1:0] - b_q);
            lo_step = {lo_q[WIDTH-2:0], !borrow};
        end else begin
            hi_step = add_sum[WIDTH:1];
            lo_step = {add_sum[0], lo_q[WIDTH-1:1]};
        end

        prod     = {hi_step, lo_step};
        prod_fix = (neg_a_q ^ neg_b_q) ? (~prod + ONE_2W) : prod;
        quot_fix = dz_q ? {WIDTH{1'b1}} :
                   ((neg_a_q ^ neg_b_q) ? (~lo_step + ONE_W) : lo_step);
        rem_fix  = dz_q ? a_raw_q : (neg_a_q ? (~hi_step + ONE_W) : hi_step);

        case (f3_q)
            3'b000:                  result_fin = prod_fix[WIDTH-1:0];
            3'b001, 3'b010, 3'b011:  result_fin = prod_fix[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:          result_fin = quot_fix;
            default:                 result_fin = rem_fix;
        endcase
    end

    always_comb begin
        f3_d     = f3_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        dz_d     = dz_q;
        a_raw_d  = a_raw_q;
        b_d      = b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        if (accept) begin
            f3_d    = i_funct3;
            neg_a_d = neg_a_in;
            neg_b_d = neg_b_in;
            dz_d    = (i_rs2 == {WIDTH{1'b0}});
            a_raw_d = i_rs1;
            b_d     = mag_b_in;
            hi_d    = {WIDTH{1'b0}};
            lo_d    = mag_a_in;
            cnt_d   = {CW{1'b0}};
        end else if (step) begin
            hi_d  = hi_step;
            lo_d  = lo_step;
            cnt_d = cnt_q + CW'(1);
            if (last) begin
                result_d = result_fin;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            f3_q     <= 3'b000;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            dz_q     <= 1'b0;
            a_raw_q  <= {WIDTH{1'b0}};
            b_q      <= {WIDTH{1'b0}};
            hi_q     <= {WIDTH{1'b0}};
            lo_q     <= {WIDTH{1'b0}};
            cnt_q    <= {CW{1'b0}};
            result_q <= {WIDTH{1'b0}};
        end else begin
            f3_q     <= f3_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            dz_q     <= dz_d;
            a_raw_q  <= a_raw_d;
            b_q      <= b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    // FSM: state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state; kill overrides everything, including a same-cycle start
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (i_start) state_d = S_BUSY;
            S_BUSY:  if (last) state_d = S_DONE;
            S_DONE:  state_d = i_start ? S_BUSY : S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (i_kill) begin
            state_d = S_IDLE;
        end
    end

    // FSM: outputs
    always_comb begin
        o_busy = (state_q == S_BUSY);
        o_done = (state_q == S_DONE);
    end

    assign o_result = result_q;

endmodule
